// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: tag allocation and in-order retire for the 32-entry temporary
// register file; owns its write port and drives arch write, store commit and redirect.
module rob_commit_ctrl #(
  parameter int ENTRIES = 32,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [4:0]       disp_rd,
  input  logic [31:0]      disp_pc,
  input  logic [1:0]       disp_type,
  output logic [TAG_W-1:0] disp_tag,
  input  logic             upd_valid,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_data,
  output logic [72:0]      tmp_data_in,
  output logic [TAG_W-1:0] tmp_waddr,
  output logic             tmp_new_entry,
  output logic             tmp_update_entry,
  output logic [TAG_W-1:0] tmp_rd_addr,
  input  logic [72:0]      tmp_rd_data,
  output logic             arch_we,
  output logic [4:0]       arch_waddr,
  output logic [31:0]      arch_wdata,
  output logic             store_commit,
  output logic [TAG_W-1:0] store_tag,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [TAG_W:0]   FULL_C    = (TAG_W+1)'(ENTRIES);
  localparam logic [TAG_W:0]   CNT_ONE_C = (TAG_W+1)'(1'b1);
  localparam logic [TAG_W-1:0] TAG_ONE_C = TAG_W'(1'b1);
  localparam logic [1:0]       TYPE_ALU    = 2'b00;
  localparam logic [1:0]       TYPE_LOAD   = 2'b01;
  localparam logic [1:0]       TYPE_STORE  = 2'b10;
  localparam logic [1:0]       TYPE_BRANCH = 2'b11;

  state_t           state_r;
  logic [TAG_W-1:0] head_r;
  logic [TAG_W-1:0] tail_r;
  logic [TAG_W:0]   count_r;

  logic             arch_we_r;
  logic [4:0]       arch_waddr_r;
  logic [31:0]      arch_wdata_r;
  logic             store_commit_r;
  logic [TAG_W-1:0] store_tag_r;
  logic             flush_r;
  logic             redirect_valid_r;
  logic [31:0]      redirect_pc_r;

  // Head entry fields: {rd, pc, type, spec_data, spec_valid, valid}
  logic [4:0]  head_rd_s;
  logic [1:0]  head_type_s;
  logic [31:0] head_spec_data_s;
  logic        head_spec_valid_s;
  logic        head_valid_s;
  logic [31:0] unused_head_pc_s;

  logic run_s;
  logic disp_ready_s;
  logic disp_fire_s;
  logic upd_write_s;
  logic retire_s;
  logic mispredict_s;

  assign head_rd_s         = tmp_rd_data[72:68];
  assign unused_head_pc_s  = tmp_rd_data[67:36];
  assign head_type_s       = tmp_rd_data[35:34];
  assign head_spec_data_s  = tmp_rd_data[33:2];
  assign head_spec_valid_s = tmp_rd_data[1];
  assign head_valid_s      = tmp_rd_data[0];

  assign run_s        = (state_r == ST_RUN);
  assign disp_ready_s = run_s && (count_r != FULL_C) && !upd_valid;
  assign disp_fire_s  = disp_valid && disp_ready_s;
  assign upd_write_s  = upd_valid && run_s;
  assign retire_s     = run_s && (count_r != {(TAG_W+1){1'b0}}) && head_valid_s && head_spec_valid_s;
  assign mispredict_s = retire_s && (head_type_s == TYPE_BRANCH) && head_spec_data_s[0];

  assign disp_ready     = disp_ready_s;
  assign disp_tag       = tail_r;
  assign tmp_rd_addr    = head_r;
  assign arch_we        = arch_we_r;
  assign arch_waddr     = arch_waddr_r;
  assign arch_wdata     = arch_wdata_r;
  assign store_commit   = store_commit_r;
  assign store_tag      = store_tag_r;
  assign flush          = flush_r;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

  // Tmp-file write port: execution updates take priority over new allocations.
  always_comb begin
    tmp_data_in      = 73'd0;
    tmp_waddr        = {TAG_W{1'b0}};
    tmp_new_entry    = 1'b0;
    tmp_update_entry = 1'b0;
    if (upd_write_s) begin
      tmp_update_entry = 1'b1;
      tmp_waddr        = upd_tag;
      tmp_data_in      = {39'd0, upd_data, 1'b1, 1'b0};
    end else if (disp_fire_s) begin
      tmp_new_entry = 1'b1;
      tmp_waddr     = tail_r;
      tmp_data_in   = {disp_rd, disp_pc, disp_type, 32'd0, 1'b0, 1'b1};
    end else begin
      tmp_new_entry = 1'b0;
    end
  end

  // Pointer/occupancy FSM and registered retire side effects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r          <= ST_RUN;
      head_r           <= {TAG_W{1'b0}};
      tail_r           <= {TAG_W{1'b0}};
      count_r          <= {(TAG_W+1){1'b0}};
      arch_we_r        <= 1'b0;
      arch_waddr_r     <= 5'd0;
      arch_wdata_r     <= 32'd0;
      store_commit_r   <= 1'b0;
      store_tag_r      <= {TAG_W{1'b0}};
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      arch_we_r        <= 1'b0;
      store_commit_r   <= 1'b0;
      flush_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (mispredict_s) begin
            // Everything younger than the branch is discarded.
            state_r          <= ST_FLUSH;
            head_r           <= {TAG_W{1'b0}};
            tail_r           <= {TAG_W{1'b0}};
            count_r          <= {(TAG_W+1){1'b0}};
            flush_r          <= 1'b1;
            redirect_valid_r <= 1'b1;
            redirect_pc_r    <= {head_spec_data_s[31:2], 2'b00};
          end else begin
            if (disp_fire_s) tail_r <= tail_r + TAG_ONE_C;
            if (retire_s) head_r <= head_r + TAG_ONE_C;
            if (disp_fire_s && !retire_s) begin
              count_r <= count_r + CNT_ONE_C;
            end else if (retire_s && !disp_fire_s) begin
              count_r <= count_r - CNT_ONE_C;
            end
            if (retire_s) begin
              case (head_type_s)
                TYPE_ALU, TYPE_LOAD: begin
                  arch_we_r    <= (head_rd_s != 5'd0);
                  arch_waddr_r <= head_rd_s;
                  arch_wdata_r <= head_spec_data_s;
                end
                TYPE_STORE: begin
                  store_commit_r <= 1'b1;
                  store_tag_r    <= head_r;
                end
                default: begin
                  store_commit_r <= 1'b0;
                end
              endcase
            end
          end
        end
        ST_FLUSH: state_r <= ST_RUN;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: directed bench with a behavioural temporary register file
// behind the controller and hand-computed expectations for each scenario.
module tb_rob_commit_ctrl;

  logic        clock;
  logic        reset;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc;
  logic [1:0]  disp_type;
  logic [4:0]  disp_tag;
  logic        upd_valid;
  logic [4:0]  upd_tag;
  logic [31:0] upd_data;
  logic [72:0] tmp_data_in;
  logic [4:0]  tmp_waddr;
  logic        tmp_new_entry;
  logic        tmp_update_entry;
  logic [4:0]  tmp_rd_addr;
  logic [72:0] tmp_rd_data;
  logic        arch_we;
  logic [4:0]  arch_waddr;
  logic [31:0] arch_wdata;
  logic        store_commit;
  logic [4:0]  store_tag;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  rob_commit_ctrl #(.ENTRIES(32), .TAG_W(5)) dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_type(disp_type), .disp_tag(disp_tag),
    .upd_valid(upd_valid), .upd_tag(upd_tag), .upd_data(upd_data),
    .tmp_data_in(tmp_data_in), .tmp_waddr(tmp_waddr),
    .tmp_new_entry(tmp_new_entry), .tmp_update_entry(tmp_update_entry),
    .tmp_rd_addr(tmp_rd_addr), .tmp_rd_data(tmp_rd_data),
    .arch_we(arch_we), .arch_waddr(arch_waddr), .arch_wdata(arch_wdata),
    .store_commit(store_commit), .store_tag(store_tag),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int checks;
  int failures;
  int cyc;
  int flush_n;
  int redirect_n;
  logic [31:0] redirect_pc_seen;
  logic [4:0]  arch_rd_q[$];
  logic [31:0] arch_data_q[$];
  int          arch_cyc_q[$];
  logic [4:0]  store_tag_q[$];
  logic [72:0] tmp_mem [32];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural regfiletmp: full write on allocation, spec fields only on update.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset || flush) begin
      for (int i = 0; i < 32; i++) tmp_mem[i] <= 73'd0;
    end else if (tmp_new_entry) begin
      tmp_mem[tmp_waddr] <= tmp_data_in;
    end else if (tmp_update_entry) begin
      tmp_mem[tmp_waddr][33:1] <= tmp_data_in[33:1];
    end
  end
  assign tmp_rd_data = tmp_mem[tmp_rd_addr];

  // Retire-side event log, sampled mid-cycle.
  always @(negedge clock) begin
    if (arch_we) begin
      arch_rd_q.push_back(arch_waddr);
      arch_data_q.push_back(arch_wdata);
      arch_cyc_q.push_back(cyc);
    end
    if (store_commit) store_tag_q.push_back(store_tag);
    if (flush) flush_n <= flush_n + 1;
    if (redirect_valid) begin
      redirect_n       <= redirect_n + 1;
      redirect_pc_seen <= redirect_pc;
    end
  end

  task automatic check_eq(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    disp_valid = 1'b0; upd_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc,
                          input logic [1:0] ty, input logic [4:0] exp_tag);
    disp_valid = 1'b1; disp_rd = rd; disp_pc = pc; disp_type = ty;
    #1;
    check_eq("disp_ready", disp_ready, 1'b1);
    check_eq("disp_tag", disp_tag, exp_tag);
    @(posedge clock); #1;
    disp_valid = 1'b0;
  endtask

  task automatic update(input logic [4:0] tag, input logic [31:0] data);
    check_eq("upd_inflight", tmp_mem[tag][0], 1'b1);
    upd_valid = 1'b1; upd_tag = tag; upd_data = data;
    #1;
    check_eq("upd_port", {tmp_update_entry, tmp_new_entry, tmp_waddr}, {1'b1, 1'b0, tag});
    @(posedge clock); #1;
    upd_valid = 1'b0;
  endtask

  initial begin
    int base;
    int upd0_cyc;
    checks = 0; failures = 0; cyc = 0; flush_n = 0; redirect_n = 0;
    disp_rd = 5'd0; disp_pc = 32'd0; disp_type = 2'b00;
    upd_tag = 5'd0; upd_data = 32'd0;

    // Reset state
    disp_valid = 1'b0; upd_valid = 1'b0; reset = 1'b1;
    #2;
    check_eq("rst_arch", {arch_we, arch_waddr, arch_wdata, store_commit, store_tag}, 73'd0);
    check_eq("rst_flush", {flush, redirect_valid, redirect_pc, tmp_rd_addr, disp_tag}, 73'd0);
    check_eq("rst_port", {tmp_new_entry, tmp_update_entry, tmp_waddr, tmp_data_in}, 73'd0);
    do_reset();

    // 1: out-of-order updates, in-order arch writes one per cycle
    base = arch_rd_q.size();
    dispatch(5'd1, 32'h100, 2'b00, 5'd0);
    dispatch(5'd2, 32'h104, 2'b00, 5'd1);
    dispatch(5'd3, 32'h108, 2'b00, 5'd2);
    update(5'd2, 32'h3333);
    upd0_cyc = cyc;
    update(5'd0, 32'h1111);
    update(5'd1, 32'h2222);
    tick(4);
    check_eq("t1_count", arch_rd_q.size() - base, 3);
    check_eq("t1_rd", {arch_rd_q[base], arch_rd_q[base+1], arch_rd_q[base+2]}, {5'd1, 5'd2, 5'd3});
    check_eq("t1_data", {arch_data_q[base], arch_data_q[base+1], arch_data_q[base+2]},
             {32'h1111, 32'h2222, 32'h3333});
    check_eq("t1_latency", arch_cyc_q[base] - upd0_cyc, 2);
    check_eq("t1_spacing", {arch_cyc_q[base+1] - arch_cyc_q[base], arch_cyc_q[base+2] - arch_cyc_q[base+1]},
             {32'd1, 32'd1});

    // 2: fill to 32, retire one, allocation wraps to tag 0
    do_reset();
    base = arch_rd_q.size();
    for (int i = 0; i < 32; i++) dispatch(5'(i + 1), 32'h1000 + 32'(4 * i), 2'b00, 5'(i));
    disp_valid = 1'b1;
    #1 check_eq("t2_full", disp_ready, 1'b0);
    disp_valid = 1'b0;
    update(5'd0, 32'h0000_AAAA);
    check_eq("t2_full_retiring", disp_ready, 1'b0);
    tick(1);
    dispatch(5'd9, 32'h2000, 2'b00, 5'd0);
    tick(1);
    check_eq("t2_arch", {arch_rd_q.size() - base, arch_rd_q[base], arch_data_q[base]},
             {32'd1, 5'd1, 32'h0000_AAAA});

    // 3: update and dispatch collide, update wins, dispatch next cycle
    do_reset();
    base = arch_rd_q.size();
    dispatch(5'd4, 32'h200, 2'b00, 5'd0);
    upd_valid = 1'b1; upd_tag = 5'd0; upd_data = 32'h5A5A;
    disp_valid = 1'b1; disp_rd = 5'd5; disp_pc = 32'h204; disp_type = 2'b01;
    #1;
    check_eq("t3_upd_ctl", {tmp_update_entry, tmp_new_entry, disp_ready, tmp_waddr}, {3'b100, 5'd0});
    check_eq("t3_upd_data", tmp_data_in, {39'd0, 32'h5A5A, 1'b1, 1'b0});
    @(posedge clock); #1;
    upd_valid = 1'b0;
    #1;
    check_eq("t3_disp_ctl", {tmp_update_entry, tmp_new_entry, disp_ready, tmp_waddr, disp_tag},
             {3'b011, 5'd1, 5'd1});
    check_eq("t3_disp_data", tmp_data_in, {5'd5, 32'h204, 2'b01, 32'd0, 1'b0, 1'b1});
    @(posedge clock); #1;
    disp_valid = 1'b0;
    tick(2);
    check_eq("t3_arch", {arch_rd_q.size() - base, arch_rd_q[base], arch_data_q[base]},
             {32'd1, 5'd4, 32'h5A5A});

    // 4: retire and dispatch together at count 5
    do_reset();
    for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 32'h300 + 32'(4 * i), 2'b00, 5'(i));
    update(5'd0, 32'h77);
    dispatch(5'd6, 32'h314, 2'b00, 5'd5);
    check_eq("t4_ptrs", {tmp_rd_addr, disp_tag}, {5'd1, 5'd6});
    for (int i = 0; i < 27; i++) dispatch(5'd7, 32'h400, 2'b00, 5'(6 + i));
    disp_valid = 1'b1;
    #1 check_eq("t4_full", disp_ready, 1'b0);
    disp_valid = 1'b0;

    // 5: mispredicted branch at head
    do_reset();
    base = arch_rd_q.size();
    dispatch(5'd0, 32'h0040_0100, 2'b11, 5'd0);
    dispatch(5'd7, 32'h0040_0104, 2'b00, 5'd1);
    dispatch(5'd8, 32'h0040_0108, 2'b00, 5'd2);
    update(5'd1, 32'h71);
    update(5'd2, 32'h81);
    update(5'd0, 32'h0040_0101);
    check_eq("t5_pre_flush", flush, 1'b0);
    @(posedge clock); #1;
    disp_valid = 1'b1; upd_valid = 1'b1; upd_tag = 5'd1; upd_data = 32'h99;
    #1;
    check_eq("t5_pulse", {flush, redirect_valid, redirect_pc}, {2'b11, 32'h0040_0100});
    check_eq("t5_stall", {disp_ready, tmp_update_entry, tmp_new_entry}, 3'b000);
    @(posedge clock); #1;
    upd_valid = 1'b0;
    #1;
    check_eq("t5_after", {flush, redirect_valid, disp_ready, disp_tag, tmp_rd_addr}, {3'b001, 5'd0, 5'd0});
    disp_valid = 1'b0;
    tick(4);
    check_eq("t5_no_commit", arch_rd_q.size() - base, 0);
    check_eq("t5_counts", {flush_n, redirect_n, redirect_pc_seen}, {32'd1, 32'd1, 32'h0040_0100});

    // 6: rd=0 suppression and store commit at tag 7
    do_reset();
    base = arch_rd_q.size();
    dispatch(5'd0, 32'h500, 2'b00, 5'd0);
    for (int i = 1; i < 7; i++) dispatch(5'(10 + i), 32'h500 + 32'(4 * i), 2'b00, 5'(i));
    dispatch(5'd0, 32'h51C, 2'b10, 5'd7);
    for (int i = 0; i < 8; i++) update(5'(i), 32'h600 + 32'(i));
    tick(3);
    check_eq("t6_arch_n", arch_rd_q.size() - base, 6);
    check_eq("t6_first", {arch_rd_q[base], arch_data_q[base]}, {5'd11, 32'h601});
    check_eq("t6_last", {arch_rd_q[base+5], arch_data_q[base+5]}, {5'd16, 32'h606});
    check_eq("t6_store", {store_tag_q.size(), store_tag_q[0]}, {32'd1, 5'd7});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
